// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with registered one-hot grant, index and hold-limit preemption
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam bit PRE_EN = MAX_HOLD != 0;
    localparam logic [7:0] LIM = PRE_EN ? 8'(MAX_HOLD - 1) : 8'd0;
    state_t state, state_n;
    logic [1:0] ptr, ptr_n, owner, owner_n, win, win_rr, win_pre, c1, c2, c3, id_n;
    logic [7:0] hold_cnt, hold_n;
    logic [3:0] gnt_n;
    logic       valid_n, take, others;
    assign c1 = ptr + 2'd1;
    assign c2 = ptr + 2'd2;
    assign c3 = ptr + 2'd3;
    assign win_rr  = req[c1] ? c1 : req[c2] ? c2 : req[c3] ? c3 : ptr;
    // preemption never reconsiders the owner, which always equals ptr while granting
    assign win_pre = req[c1] ? c1 : req[c2] ? c2 : c3;
    assign others  = |(req & ~(4'b0001 << owner));
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        id_n    = gnt_id;
        valid_n = gnt_valid;
        take    = 1'b0;
        win     = win_rr;
        if (state == IDLE) begin
            take = |req;
        end else if (!req[owner]) begin
            take = |req;
            if (!(|req)) begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                id_n    = 2'd0;
                valid_n = 1'b0;
            end
        end else if (!PRE_EN || hold_cnt < LIM) begin
            hold_n = hold_cnt + 8'd1;
        end else if (others) begin
            take = 1'b1;
            win  = win_pre;
        end
        if (take) begin
            state_n = GRANT;
            owner_n = win;
            ptr_n   = win;
            hold_n  = 8'd0;
            gnt_n   = 4'b0001 << win;
            id_n    = win;
            valid_n = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            owner     <= 2'd0;
            hold_cnt  <= 8'd0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
        end
    end
endmodule
